// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multi-cycle RISC-V core: decodes the latched opcode,
// drives datapath mux selects and write enables, and counts retired instructions.
module multicycle_control_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic                 mem_ready,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_op,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_update,
  output logic                 branch,
  output logic                 reg_write,
  output logic                 mem_write,
  output logic                 illegal_op,
  output logic [3:0]           state_o,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                 retire;
  logic                 ir_w, pc_u, br, reg_w, mem_w, ill;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    adr_src    = 1'b0;
    ir_w       = 1'b0;
    pc_u       = 1'b0;
    br         = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ill        = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_w       = mem_ready;
        pc_u       = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            state_d = S_FETCH;
            ill     = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        // Only lw/sw reach here; opcode bit 5 tells them apart.
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_u      = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        br        = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are gated by reset so an in-flight store is dropped immediately.
  assign ir_write   = ir_w  & ~reset;
  assign pc_update  = pc_u  & ~reset;
  assign branch     = br    & ~reset;
  assign reg_write  = reg_w & ~reset;
  assign mem_write  = mem_w & ~reset;
  assign illegal_op = ill   & ~reset;
  assign state_o    = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized instruction-stream bench for multicycle_control_fsm, checked every
// cycle against a per-instruction state-path model and a state->output table.
module tb_multicycle_control_fsm;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    op;
  logic          mem_ready;
  logic [1:0]    alu_src_a, alu_src_b, result_src, alu_op;
  logic          adr_src, ir_write, pc_update, branch, reg_write, mem_write, illegal_op;
  logic [3:0]    state_o;
  logic [CW-1:0] retired;

  int n_cmp = 0;
  int n_bad = 0;
  int model_ret = 0;

  logic [6:0] legal_ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                7'b0010011, 7'b1101111, 7'b1100011};

  multicycle_control_fsm #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_op(alu_op), .adr_src(adr_src), .ir_write(ir_write),
    .pc_update(pc_update), .branch(branch), .reg_write(reg_write),
    .mem_write(mem_write), .illegal_op(illegal_op), .state_o(state_o),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 beq, -1 unsupported
  function automatic int kind(input logic [6:0] o);
    case (o)
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011: return 2;
      7'b0010011: return 3;
      7'b1101111: return 4;
      7'b1100011: return 5;
      default:    return -1;
    endcase
  endfunction

  // {alu_src_a, alu_src_b, result_src, alu_op, adr_src, ir_write, pc_update,
  //  branch, reg_write, mem_write, illegal_op}
  function automatic logic [14:0] exp_out(input int st, input logic mr,
                                          input logic rst, input logic [6:0] o);
    logic [1:0] a, b, r, ao;
    logic adr, irw, pcu, br, rw, mw, ill;
    {a, b, r, ao} = '0;
    {adr, irw, pcu, br, rw, mw, ill} = '0;
    case (st)
      0:  begin b = 2'b10; r = 2'b10; irw = mr; pcu = mr; end
      1:  begin a = 2'b01; b = 2'b01; ill = (kind(o) < 0); end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  begin adr = 1'b1; end
      4:  begin r = 2'b01; rw = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; end
      6:  begin a = 2'b10; ao = 2'b10; end
      7:  begin rw = 1'b1; end
      8:  begin a = 2'b10; b = 2'b01; ao = 2'b10; end
      9:  begin a = 2'b01; b = 2'b10; pcu = 1'b1; end
      10: begin a = 2'b10; ao = 2'b01; br = 1'b1; end
      default: ;
    endcase
    if (rst) {irw, pcu, br, rw, mw, ill} = '0;
    return {a, b, r, ao, adr, irw, pcu, br, rw, mw, ill};
  endfunction

  task automatic check(input int st, input logic mr, input logic rst, input logic [6:0] o);
    logic [14:0] exp_v, got_v;
    exp_v = exp_out(st, mr, rst, o);
    got_v = {alu_src_a, alu_src_b, result_src, alu_op, adr_src, ir_write,
             pc_update, branch, reg_write, mem_write, illegal_op};
    n_cmp++;
    assert (state_o === 4'(st)) else begin
      n_bad++;
      $error("FAIL state: got %0d expected %0d", state_o, st);
    end
    n_cmp++;
    assert (got_v === exp_v) else begin
      n_bad++;
      $error("FAIL outputs(st=%0d mr=%0b rst=%0b): got %b expected %b", st, mr, rst, got_v, exp_v);
    end
    n_cmp++;
    assert (retired === CW'(model_ret)) else begin
      n_bad++;
      $error("FAIL retired(st=%0d): got %0d expected %0d", st, retired, model_ret);
    end
  endtask

  task automatic cyc(input int st, input logic mr, input logic [6:0] o);
    op = o;
    mem_ready = mr;
    @(negedge clk);
    check(st, mr, reset, o);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic retire_one();
    model_ret = (model_ret + 1) % (1 << CW);
  endtask

  task automatic run_instr(input logic [6:0] o, input int fs, input int ms);
    for (int i = 0; i < fs; i++) cyc(0, 1'b0, rop());
    cyc(0, 1'b1, rop());
    cyc(1, rb(), o);
    case (kind(o))
      0: begin
        cyc(2, rb(), o);
        for (int i = 0; i < ms; i++) cyc(3, 1'b0, rop());
        cyc(3, 1'b1, rop());
        cyc(4, rb(), rop());
        retire_one();
      end
      1: begin
        cyc(2, rb(), o);
        for (int i = 0; i < ms; i++) cyc(5, 1'b0, rop());
        cyc(5, 1'b1, rop());
        retire_one();
      end
      2: begin cyc(6, rb(), rop()); cyc(7, rb(), rop()); retire_one(); end
      3: begin cyc(8, rb(), rop()); cyc(7, rb(), rop()); retire_one(); end
      4: begin cyc(9, rb(), rop()); cyc(7, rb(), rop()); retire_one(); end
      5: begin cyc(10, rb(), rop()); retire_one(); end
      default: ;
    endcase
  endtask

  initial begin
    logic [6:0] o;
    reset = 1'b1;
    mem_ready = 1'b0;
    op = 7'd0;
    @(posedge clk);
    #1;
    cyc(0, 1'b0, rop());
    cyc(0, 1'b1, rop());
    reset = 1'b0;
    model_ret = 0;

    run_instr(7'b0000011, 3, 0);
    run_instr(7'b0100011, 0, 2);
    run_instr(7'b0110011, 0, 0);
    run_instr(7'b0010011, 1, 0);
    run_instr(7'b1101111, 0, 0);
    run_instr(7'b1100011, 0, 0);
    run_instr(7'b1111111, 0, 0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) < 6) o = legal_ops[$urandom_range(0, 5)];
      else o = rop();
      run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    if (model_ret == 0) run_instr(7'b0110011, 0, 0);
    cyc(0, 1'b1, rop());
    cyc(1, 1'b0, 7'b0100011);
    cyc(2, 1'b0, 7'b0100011);
    cyc(5, 1'b0, rop());
    reset = 1'b1;
    cyc(5, 1'b1, rop());
    reset = 1'b0;
    model_ret = 0;
    run_instr(7'b0000011, 1, 1);

    for (int n = 0; n < (1 << CW); n++) run_instr(7'b1100011, 0, 0);
    cyc(0, 1'b0, rop());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control state machine for the multi-cycle RISC-V core. It decodes the opcode latched in the instruction register and sequences each instruction through fetch, decode, execute, memory and writeback states. It is the producer of the 2-bit select codes that the datapath's three-input muxes consume (ALU A, ALU B, result), and of all write enables. It also waits on a memory-ready handshake and counts retired instructions.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter (wraps modulo 2^CNT_WIDTH)

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
op  input  7  instruction opcode bits [6:0] from the instruction register
mem_ready  input  1  memory completes the current access this cycle
alu_src_a  output  2  00 PC, 01 OldPC, 10 register A; 11 never driven
alu_src_b  output  2  00 register WriteData, 01 ImmExt, 10 constant 4; 11 never driven
result_src  output  2  00 ALUOut, 01 memory Data, 10 ALUResult; 11 never driven
alu_op  output  2  00 add, 01 subtract/compare, 10 funct-decoded
adr_src  output  1  0 PC, 1 Result as memory address
ir_write  output  1  instruction register load enable
pc_update  output  1  unconditional PC load
branch  output  1  conditional PC load qualifier (PC loads if branch & zero)
reg_write  output  1  register file write enable
mem_write  output  1  data memory write enable
illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode
state_o  output  4  current state encoding, for debug
retired  output  CNT_WIDTH  count of completed instructions

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10. Codes 11-15 are unreachable and go to FETCH on the next edge.
- Outputs are a combinational function of the state, plus mem_ready where noted. Any output not listed for a state is 0; in particular every select is 00 and every enable is 0.
- FETCH:
  - Drives adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_update equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00. Next state by op:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other op -> FETCH, with illegal_op=1 for this cycle; the instruction is not counted.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: result_src=00, adr_src=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1. mem_write stays asserted every cycle until mem_ready=1, then -> FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1 -> FETCH.
- op is sampled in DECODE and MEMADR only. op changing in any other state has no effect.
- retired:
  - Increments by 1 on every edge that takes MEMWB, MEMWRITE (with mem_ready=1), ALUWB or BEQ to FETCH.
  - Wraps from all-ones to 0.
  - Latency: the new value is visible the cycle after the completing state.
- Reset:
  - When reset=1 at a rising edge, state becomes FETCH and retired becomes 0, regardless of current state or mem_ready.
  - While reset=1, ir_write, pc_update, reg_write, mem_write, branch and illegal_op are forced to 0; selects follow the current state.
  - After reset: state_o=0, retired=0, outputs are FETCH values.
  - Reset mid-MEMWRITE aborts the write in the same cycle; no increment occurs.
- reset takes priority over mem_ready and all transitions.

Test Plan:
- Reset and stalled fetch:
  - Stimulus: reset 2 cycles, release with mem_ready=0 for 3 cycles.
  - Required: state_o=0, ir_write=0, alu_src_b=10, result_src=10 throughout.
  - Then raise mem_ready=1: ir_write=pc_update=1 that cycle, state_o=1 next.
- lw, op=0000011, mem_ready held 1:
  - States 0,1,2,3,4,0.
  - MEMREAD: adr_src=1. MEMWB: result_src=01, reg_write=1. retired 0->1.
- sw, op=0100011, mem_ready=0 for 2 MEMWRITE cycles then 1:
  - mem_write=1 for all 3 MEMWRITE cycles, then FETCH; retired +1.
- R-type 0110011 then I-type 0010011:
  - EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. EXECI: alu_src_b=01.
  - Both pass through ALUWB with reg_write=1; retired +2.
- jal 1101111 and beq 1100011:
  - JAL: pc_update=1, alu_src_a=01, alu_src_b=10, then ALUWB.
  - BEQ: branch=1, alu_op=01, back to FETCH.
  - Selects never equal 11 in any cycle.
- Illegal opcode and reset edge cases:
  - op=1111111 in DECODE: illegal_op=1 for exactly one cycle, next state FETCH, retired unchanged.
  - reset asserted in MEMWRITE: mem_write=0 that cycle, state_o=0 and retired=0 next.
  - Preload retired=0xFFFFFFFF via a long run or force, complete one instruction: retired=0.
